// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO with valid/ready on both sides, an occupancy
// count, a programmable almost-full flag and a synchronous flush. DEPTH does
// not need to be a power of two because the pointers wrap explicitly.
module param_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AFULL = DEPTH - 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_afull
);

    localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_CNT   = CW'(AFULL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Status outputs come only from registered state, never from the inputs.
    assign o_ready = (cnt != FULL_CNT);
    assign o_valid = (cnt != '0);
    assign o_count = cnt;
    assign o_afull = (cnt >= AF_CNT);
    assign o_data  = mem[rp];

    // A flush cancels any handshake that happens to coincide with it.
    assign push = i_valid & o_ready & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    // Storage array is written on accepted pushes only; it is never cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= i_data;
        end
    end

    // Pointers and occupancy; flush returns them to empty like a reset does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (i_flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= (wp == LAST_IDX) ? '0 : wp + 1'b1;
            end
            if (pop) begin
                rp <= (rp == LAST_IDX) ? '0 : rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: three FIFO configurations (8x4, 8x3, 8x8 with afull at 5)
// share one clock and reset. Only one instance is exercised at a time, so a
// single expected-data queue serves all of them; a monitor compares every
// popped word against the front of that queue.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_in [3];
    logic       r_in [3];
    logic       f_in [3];
    logic [7:0] d_in [3];

    logic       out_valid [3];
    logic       out_ready [3];
    logic       out_afull [3];
    logic [7:0] out_data  [3];
    logic [3:0] cnt_v     [3];

    logic [2:0] count0;
    logic [1:0] count1;
    logic [3:0] count2;

    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    param_fifo u_fifo4 (
        .clk(clk), .rst_n(rst_n), .i_flush(f_in[0]), .i_valid(v_in[0]),
        .o_ready(out_ready[0]), .i_data(d_in[0]), .o_valid(out_valid[0]),
        .i_ready(r_in[0]), .o_data(out_data[0]), .o_count(count0),
        .o_afull(out_afull[0])
    );

    param_fifo #(.WIDTH(8), .DEPTH(3)) u_fifo3 (
        .clk(clk), .rst_n(rst_n), .i_flush(f_in[1]), .i_valid(v_in[1]),
        .o_ready(out_ready[1]), .i_data(d_in[1]), .o_valid(out_valid[1]),
        .i_ready(r_in[1]), .o_data(out_data[1]), .o_count(count1),
        .o_afull(out_afull[1])
    );

    param_fifo #(.WIDTH(8), .DEPTH(8), .AFULL(5)) u_fifo8 (
        .clk(clk), .rst_n(rst_n), .i_flush(f_in[2]), .i_valid(v_in[2]),
        .o_ready(out_ready[2]), .i_data(d_in[2]), .o_valid(out_valid[2]),
        .i_ready(r_in[2]), .o_data(out_data[2]), .o_count(count2),
        .o_afull(out_afull[2])
    );

    assign cnt_v[0] = {1'b0, count0};
    assign cnt_v[1] = {2'b00, count1};
    assign cnt_v[2] = count2;

    // Monitor: a pop happens at the next rising edge whenever valid and ready
    // are both high without a flush; the head word must match the scoreboard.
    always @(negedge clk) begin
        logic [7:0] exp_d;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && out_valid[k] && r_in[k] && !f_in[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pop_data inst%0d got %02h, expected no pop", k, out_data[k]);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (out_data[k] !== exp_d) begin
                        errors++;
                        $display("[TB] FAIL pop_data inst%0d got %02h expected %02h", k, out_data[k], exp_d);
                    end
                end
            end
        end
    end

    // Drives one cycle of inputs on instance k and records the word the
    // scoreboard expects to be accepted; returns just after the clock edge.
    task automatic applyStimulus(input int k, input bit v, input logic [7:0] d,
                                 input bit r, input bit f, input bit exp_push);
        v_in[k] = v;
        d_in[k] = d;
        r_in[k] = r;
        f_in[k] = f;
        if (f) exp_q.delete();
        if (exp_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Compares the status outputs of instance k against hand-computed values.
    task automatic checkOutput(input int k, input string name, input int ec,
                               input bit ev, input bit er, input bit ea);
        logic [6:0] got;
        logic [6:0] exp;
        got = {cnt_v[k], out_valid[k], out_ready[k], out_afull[k]};
        exp = {ec[3:0], ev, er, ea};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d got count=%0d valid=%b ready=%b afull=%b expected count=%0d valid=%b ready=%b afull=%b",
                     name, k, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            v_in[k] = 1'b0; r_in[k] = 1'b0; f_in[k] = 1'b0; d_in[k] = 8'h00;
        end
        // Reset held with a write request pending: nothing may be accepted.
        rst_n   = 1'b0;
        v_in[0] = 1'b1;
        d_in[0] = 8'h99;
        #3;
        checkOutput(0, "reset_async", 0, 0, 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput(0, "reset_no_push", 0, 0, 1, 0);
        v_in[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput(0, "after_release", 0, 0, 1, 0);

        // Fill the 4-deep FIFO, try an extra push, then drain it.
        applyStimulus(0, 1, 8'h11, 0, 0, 1); checkOutput(0, "fill1", 1, 1, 1, 0);
        applyStimulus(0, 1, 8'h22, 0, 0, 1); checkOutput(0, "fill2", 2, 1, 1, 0);
        applyStimulus(0, 1, 8'h33, 0, 0, 1); checkOutput(0, "fill3", 3, 1, 1, 1);
        applyStimulus(0, 1, 8'h44, 0, 0, 1); checkOutput(0, "fill4", 4, 1, 0, 1);
        applyStimulus(0, 1, 8'h55, 0, 0, 0); checkOutput(0, "refused5", 4, 1, 0, 1);
        applyStimulus(0, 1, 8'h55, 0, 0, 0); checkOutput(0, "refused5b", 4, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "drain3", 3, 1, 1, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "drain2", 2, 1, 1, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "drain1", 1, 1, 1, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "drain0", 0, 0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);

        // Full with a simultaneous pop: pop happens, the push waits a cycle.
        applyStimulus(0, 1, 8'hA1, 0, 0, 1);
        applyStimulus(0, 1, 8'hA2, 0, 0, 1);
        applyStimulus(0, 1, 8'hA3, 0, 0, 1);
        applyStimulus(0, 1, 8'hA4, 0, 0, 1); checkOutput(0, "full_pre", 4, 1, 0, 1);
        applyStimulus(0, 1, 8'hB5, 1, 0, 0); checkOutput(0, "full_pop", 3, 1, 1, 1);
        applyStimulus(0, 1, 8'hB5, 0, 0, 1); checkOutput(0, "full_refill", 4, 1, 0, 1);
        for (int j = 0; j < 4; j++) applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput(0, "full_drained", 0, 0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);

        // Flush at count 3 with a push and pop in the same cycle.
        applyStimulus(0, 1, 8'h01, 0, 0, 1);
        applyStimulus(0, 1, 8'h02, 0, 0, 1);
        applyStimulus(0, 1, 8'h03, 0, 0, 1); checkOutput(0, "flush_pre", 3, 1, 1, 1);
        applyStimulus(0, 1, 8'hEE, 1, 1, 0); checkOutput(0, "flush_empty", 0, 0, 1, 0);
        applyStimulus(0, 1, 8'hA5, 0, 0, 1); checkOutput(0, "flush_push", 1, 1, 1, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "flush_read", 0, 0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);

        // Wrap-around on the 3-deep FIFO: prefill two, then stream 2..19.
        applyStimulus(1, 1, 8'd0, 0, 0, 1); checkOutput(1, "wrap_pre1", 1, 1, 1, 0);
        applyStimulus(1, 1, 8'd1, 0, 0, 1); checkOutput(1, "wrap_pre2", 2, 1, 1, 1);
        for (int i = 2; i < 20; i++) begin
            applyStimulus(1, 1, 8'(i), 1, 0, 1);
            checkOutput(1, "wrap_stream", 2, 1, 1, 1);
        end
        applyStimulus(1, 0, 8'h00, 1, 0, 0); checkOutput(1, "wrap_drain1", 1, 1, 1, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 0); checkOutput(1, "wrap_drain0", 0, 0, 1, 0);
        applyStimulus(1, 0, 8'h00, 0, 0, 0);

        // Almost-full threshold of 5 on the 8-deep FIFO, fill then drain.
        checkOutput(2, "afull_fill", 0, 0, 1, 0);
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(2, 1, 8'(8'h80 + n), 0, 0, 1);
            checkOutput(2, "afull_fill", n, 1, n != 8, n >= 5);
        end
        for (int n = 7; n >= 0; n--) begin
            applyStimulus(2, 0, 8'h00, 1, 0, 0);
            checkOutput(2, "afull_drain", n, n != 0, 1, n >= 5);
        end
        applyStimulus(2, 0, 8'h00, 0, 0, 0);

        // Asynchronous reset in the middle of a transfer drops stored words.
        applyStimulus(0, 1, 8'h61, 0, 0, 1);
        applyStimulus(0, 1, 8'h62, 0, 0, 1); checkOutput(0, "midrst_pre", 2, 1, 1, 0);
        v_in[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkOutput(0, "midrst_async", 0, 0, 1, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput(0, "midrst_after", 0, 0, 1, 0);

        // Every word the scoreboard expected must have been popped.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover got %0d words still expected, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
